fir_frame_sched: RTL

Sequencer between the sample source and the 16-tap-pair FIR datapath. It gates and registers samples into the FIR and masks the FIR's pipeline warm-up. It packs valid FIR outputs into 16-sample frames in a ping-pong buffer and hands each complete frame to the FFT stage over a valid/ready handshake.

---
 rtl/fas_pkg.sv | 19 +
 rtl/frame_pingpong.sv | 89 ++++++++
 rtl/fir_frame_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// ------------------------------------------------------------------
// fas_pkg: shared defaults and FSM encoding for fir_frame_sched.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fas_pkg;
  localparam int DW_DEF      = 16;
  localparam int FRAME_N_DEF = 16;
  localparam int FIR_LAT_DEF = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/frame_pingpong.sv
// ------------------------------------------------------------------
// frame_pingpong: two-bank frame buffer, sample write port, frame valid/ready.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module frame_pingpong import fas_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int FRAME_N = FRAME_N_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic [DW-1:0]           i_wr_data,
  output logic                    o_drop,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic                    o_hs,
  output logic [FRAME_N*DW-1:0]   o_data
);
  localparam int             IW     = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;
  localparam logic [IW-1:0]  c_LAST = IW'(FRAME_N - 1);

  logic [DW-1:0] r_bank [2][FRAME_N];
  logic [1:0]    r_full;
  logic [1:0]    w_full_nxt;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_idx;
  logic          w_hs;
  logic          w_blocked;
  logic          w_write;
  logic          w_last;

  assign w_hs      = r_full[r_rd_bank] & i_ready;
  // A handshake on the bank the writer is waiting for frees it this same cycle.
  assign w_blocked = r_full[r_wr_bank] & ~(w_hs & (r_rd_bank == r_wr_bank));
  assign o_drop    = i_wr_en & (r_wr_idx == '0) & w_blocked;
  assign w_write   = i_wr_en & ~o_drop;
  assign w_last    = (r_wr_idx == c_LAST);

  always_comb begin
    w_full_nxt = r_full;
    if (w_hs)
      w_full_nxt[r_rd_bank] = 1'b0;
    if (w_write && w_last)
      w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_hs)
        r_rd_bank <= ~r_rd_bank;
      if (i_clr) begin
        r_wr_idx <= '0;
      end else if (w_write) begin
        if (w_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write)
      r_bank[r_wr_bank][r_wr_idx] <= i_wr_data;
  end

  generate
    for (genvar k = 0; k < FRAME_N; k++) begin : g_out
      assign o_data[k*DW +: DW] = r_bank[r_rd_bank][k];
    end
  endgenerate

  assign o_valid = r_full[r_rd_bank];
  assign o_hs    = w_hs;
endmodule

`default_nettype wire

// File: rtl/fir_frame_sched.sv
// ------------------------------------------------------------------
// fir_frame_sched: FIR input gating, warm-up masking and frame hand-off to FFT.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fir_frame_sched import fas_pkg::*; #(
  parameter int FRAME_N = FRAME_N_DEF,
  parameter int FIR_LAT = FIR_LAT_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  fir_data_valid,
  output logic [DW-1:0]         fir_data,
  input  logic                  fir_valid,
  input  logic [DW-1:0]         fir_d,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [FRAME_N*DW-1:0] frame_data,
  output logic [15:0]           frame_cnt,
  output logic                  overflow,
  input  logic                  clr_ovf
);
  localparam int LW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

  state_e        r_state;
  logic [LW-1:0] r_lat_cnt;
  logic          r_fdv;
  logic [DW-1:0] r_fd;
  logic          r_ovf;
  logic [15:0]   r_frame_cnt;
  logic          w_go;
  logic          w_warm_done;
  logic          w_cap;
  logic          w_drop;
  logic          w_hs;

  assign w_go        = in_valid & en;
  assign w_warm_done = (FIR_LAT == 0) || (int'(r_lat_cnt) == FIR_LAT - 1);
  assign w_cap       = (r_state == RUN) & w_go & fir_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state   <= WARM;
            r_lat_cnt <= '0;
          end
        end
        WARM: begin
          if (!w_go) begin
            r_state <= IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + LW'(1);
            if (w_warm_done)
              r_state <= RUN;
          end
        end
        RUN: begin
          if (!w_go)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated samples go to the FIR; zero data while idle keeps its taps quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fdv       <= 1'b0;
      r_fd        <= '0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_fdv <= w_go;
      r_fd  <= w_go ? in_data : '0;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
      if (w_hs)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  frame_pingpong #(
    .DW      (DW),
    .FRAME_N (FRAME_N)
  ) u_pingpong (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (~w_go),
    .i_wr_en   (w_cap),
    .i_wr_data (fir_d),
    .o_drop    (w_drop),
    .i_ready   (frame_ready),
    .o_valid   (frame_valid),
    .o_hs      (w_hs),
    .o_data    (frame_data)
  );

  assign fir_data_valid = r_fdv;
  assign fir_data       = r_fd;
  assign frame_cnt      = r_frame_cnt;
  assign overflow       = r_ovf;
endmodule

`default_nettype wire
